// File: rtl/config_bus_master.sv
// ---------------------------------------------------------------------------
// config_bus_master
// Initiator for the tile configuration bus. It accepts one write or read
// command at a time over a valid/ready channel and drives config_addr,
// config_data and config_en to the tile array. For a read, it samples the
// tile's read data after a fixed latency and returns it on a valid/ready
// response channel.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake; cmd_write selects write (1) / read (0)
//   cmd_addr, cmd_data   : command address and write data
//   rsp_valid/rsp_ready  : read response handshake; rsp_data carries the read value
//   config_addr/_data/_en: tile configuration bus outputs
//   config_read_data     : tile read data input
//   busy                 : high whenever the master is not idle
//   write_count          : saturating count of completed writes
// ---------------------------------------------------------------------------
module config_bus_master #(
    parameter int unsigned WRITE_CYCLES = 1,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [31:0]            cmd_addr,
    input  logic [31:0]            cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [31:0]            config_addr,
    output logic [31:0]            config_data,
    output logic                   config_en,
    input  logic [31:0]            config_read_data,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] write_count
);

    // Counter must hold up to max(WRITE_CYCLES, READ_LATENCY) - 1.
    localparam int unsigned MAX_CYC = (WRITE_CYCLES > READ_LATENCY) ? WRITE_CYCLES : READ_LATENCY;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]       WR_LOAD   = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       RD_LOAD   = CNT_W'(READ_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic [31:0]            config_addr_q, config_addr_d;
    logic [31:0]            config_data_q, config_data_d;
    logic                   config_en_q, config_en_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] write_count_q, write_count_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        config_addr_d = config_addr_q;
        config_data_d = config_data_q;
        config_en_d   = config_en_q;
        write_count_d = write_count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    config_addr_d = cmd_addr;
                    if (cmd_write) begin
                        config_data_d = cmd_data;
                        config_en_d   = 1'b1;
                        cnt_d         = WR_LOAD;
                        state_d       = WRITE;
                    end else begin
                        cnt_d   = RD_LOAD;
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    config_en_d = 1'b0;
                    if (write_count_q != COUNT_MAX) begin
                        write_count_d = write_count_q + COUNT_WIDTH'(1);
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = config_read_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered status: both reflect the state being entered.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            config_addr_q <= '0;
            config_data_q <= '0;
            config_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            config_addr_q <= config_addr_d;
            config_data_q <= config_data_d;
            config_en_q   <= config_en_d;
            busy_q        <= busy_d;
            write_count_q <= write_count_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign config_addr = config_addr_q;
    assign config_data = config_data_q;
    assign config_en   = config_en_q;
    assign busy        = busy_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_config_bus_master.sv
// ---------------------------------------------------------------------------
// tb_config_bus_master
// Directed bench for config_bus_master. Instance A: WRITE_CYCLES=1,
// READ_LATENCY=3, COUNT_WIDTH=2 against a constant read-data stub.
// Instance B: WRITE_CYCLES=4, READ_LATENCY=1, COUNT_WIDTH=16 against a
// small register-file tile stub.
// ---------------------------------------------------------------------------
module tb_config_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A signals ----------------
    logic        reset_a;
    logic        cmd_valid_a, cmd_ready_a, cmd_write_a;
    logic [31:0] cmd_addr_a, cmd_data_a;
    logic        rsp_valid_a, rsp_ready_a;
    logic [31:0] rsp_data_a, config_addr_a, config_data_a, rd_a;
    logic        config_en_a, busy_a;
    logic [1:0]  write_count_a;

    // ---------------- instance B signals ----------------
    logic        reset_b;
    logic        cmd_valid_b, cmd_ready_b, cmd_write_b;
    logic [31:0] cmd_addr_b, cmd_data_b;
    logic        rsp_valid_b, rsp_ready_b;
    logic [31:0] rsp_data_b, config_addr_b, config_data_b, rd_b;
    logic        config_en_b, busy_b;
    logic [15:0] write_count_b;

    config_bus_master #(.WRITE_CYCLES(1), .READ_LATENCY(3), .COUNT_WIDTH(2)) u_dut_a (
        .clk(clk), .reset(reset_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write_a),
        .cmd_addr(cmd_addr_a), .cmd_data(cmd_data_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
        .config_addr(config_addr_a), .config_data(config_data_a), .config_en(config_en_a),
        .config_read_data(rd_a), .busy(busy_a), .write_count(write_count_a)
    );

    config_bus_master #(.WRITE_CYCLES(4), .READ_LATENCY(1), .COUNT_WIDTH(16)) u_dut_b (
        .clk(clk), .reset(reset_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
        .cmd_addr(cmd_addr_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .config_addr(config_addr_b), .config_data(config_data_b), .config_en(config_en_b),
        .config_read_data(rd_b), .busy(busy_b), .write_count(write_count_b)
    );

    // Tile stub for B: 16-entry register file written while config_en is high.
    logic [31:0] tile_mem [16];
    initial for (int i = 0; i < 16; i++) tile_mem[i] = '0;
    always @(posedge clk) if (config_en_b) tile_mem[config_addr_b[3:0]] <= config_data_b;
    assign rd_b = tile_mem[config_addr_b[3:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_a = 1'b1; cmd_valid_a = 1'b0; cmd_write_a = 1'b0;
        cmd_addr_a = '0; cmd_data_a = '0; rsp_ready_a = 1'b0; rd_a = 32'hDEADBEEF;
        reset_b = 1'b1; cmd_valid_b = 1'b0; cmd_write_b = 1'b0;
        cmd_addr_b = '0; cmd_data_b = '0; rsp_ready_b = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk("a_rst_en",    32'(config_en_a),   32'd0);
        chk("a_rst_busy",  32'(busy_a),        32'd0);
        chk("a_rst_wc",    32'(write_count_a), 32'd0);
        chk("a_rst_addr",  config_addr_a,      32'd0);
        chk("a_rst_data",  config_data_a,      32'd0);
        chk("a_rst_rspv",  32'(rsp_valid_a),   32'd0);
        chk("a_rst_rspd",  rsp_data_a,         32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();
        chk("a_ready_after_rst", 32'(cmd_ready_a), 32'd1);

        // ---------------- A: single write, WRITE_CYCLES=1 ----------------
        cmd_valid_a = 1'b1; cmd_write_a = 1'b1; cmd_addr_a = 32'h0; cmd_data_a = 32'h1;
        step();
        cmd_valid_a = 1'b0; cmd_data_a = 32'hFFFF_FFFF;
        chk("a_w1_en",    32'(config_en_a), 32'd1);
        chk("a_w1_addr",  config_addr_a,    32'h0);
        chk("a_w1_data",  config_data_a,    32'h1);
        chk("a_w1_rdy",   32'(cmd_ready_a), 32'd0);
        chk("a_w1_busy",  32'(busy_a),      32'd1);
        step();
        chk("a_w1_en_off", 32'(config_en_a),   32'd0);
        chk("a_w1_wc",     32'(write_count_a), 32'd1);
        chk("a_w1_rdy2",   32'(cmd_ready_a),   32'd1);
        chk("a_w1_hold",   config_data_a,      32'h1);
        step();
        chk("a_idle_en",   32'(config_en_a),   32'd0);

        // ---------------- A: saturation, back-to-back writes ----------------
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        step();
        cmd_valid_a = 1'b1; cmd_write_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_addr_a = 32'(k + 1); cmd_data_a = 32'(k + 16);
            step();
            chk("a_sat_en",   32'(config_en_a), 32'd1);
            chk("a_sat_addr", config_addr_a,    32'(k + 1));
            chk("a_sat_rdy0", 32'(cmd_ready_a), 32'd0);
            step();
            chk("a_sat_wc",   32'(write_count_a), (k < 3) ? 32'(k + 1) : 32'd3);
            chk("a_sat_rdy1", 32'(cmd_ready_a),   32'd1);
            chk("a_sat_enof", 32'(config_en_a),   32'd0);
        end
        cmd_valid_a = 1'b0;
        step();

        // ---------------- A: read with READ_LATENCY=3, then backpressure ----------------
        rd_a = 32'hDEADBEEF;
        cmd_valid_a = 1'b1; cmd_write_a = 1'b0; cmd_addr_a = 32'h10;
        step();
        cmd_valid_a = 1'b0;
        chk("a_rd_addr", config_addr_a,    32'h10);
        chk("a_rd_en",   32'(config_en_a), 32'd0);
        chk("a_rd_busy", 32'(busy_a),      32'd1);
        for (int c = 1; c < 3; c++) begin
            step();
            chk("a_rd_wait_v", 32'(rsp_valid_a), 32'd0);
        end
        step();
        chk("a_rd_v",    32'(rsp_valid_a), 32'd1);
        chk("a_rd_data", rsp_data_a,       32'hDEADBEEF);
        // Hold off the response; stray commands must be ignored meanwhile.
        cmd_valid_a = 1'b1; cmd_write_a = 1'b1; cmd_addr_a = 32'h20; cmd_data_a = 32'h5;
        for (int c = 0; c < 5; c++) begin
            rd_a = 32'h1234_0000 + 32'(c);
            step();
            chk("a_bp_v",    32'(rsp_valid_a), 32'd1);
            chk("a_bp_data", rsp_data_a,       32'hDEADBEEF);
            chk("a_bp_rdy",  32'(cmd_ready_a), 32'd0);
            chk("a_bp_busy", 32'(busy_a),      32'd1);
            chk("a_bp_en",   32'(config_en_a), 32'd0);
        end
        cmd_valid_a = 1'b0;
        rsp_ready_a = 1'b1;
        step();
        rsp_ready_a = 1'b0;
        chk("a_hs_v",    32'(rsp_valid_a),   32'd0);
        chk("a_hs_busy", 32'(busy_a),        32'd0);
        chk("a_hs_rdy",  32'(cmd_ready_a),   32'd1);
        chk("a_hs_addr", config_addr_a,      32'h10);
        chk("a_hs_wc",   32'(write_count_a), 32'd3);
        step();
        chk("a_hs_once", 32'(rsp_valid_a),   32'd0);

        // ---------------- B: write WRITE_CYCLES=4 then read back ----------------
        cmd_valid_b = 1'b1; cmd_write_b = 1'b1; cmd_addr_b = 32'h3; cmd_data_b = 32'h8;
        step();
        cmd_valid_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("b_w_en",   32'(config_en_b), 32'd1);
            chk("b_w_addr", config_addr_b,    32'h3);
            chk("b_w_data", config_data_b,    32'h8);
            step();
        end
        chk("b_w_enof", 32'(config_en_b),   32'd0);
        chk("b_w_wc",   32'(write_count_b), 32'd1);
        chk("b_w_rdy",  32'(cmd_ready_b),   32'd1);
        cmd_valid_b = 1'b1; cmd_write_b = 1'b0; cmd_addr_b = 32'h3;
        rsp_ready_b = 1'b1;
        step();
        cmd_valid_b = 1'b0;
        chk("b_r_v0", 32'(rsp_valid_b), 32'd0);
        step();
        chk("b_r_v",    32'(rsp_valid_b), 32'd1);
        chk("b_r_data", rsp_data_b,       32'h8);
        step();
        rsp_ready_b = 1'b0;
        chk("b_r_done", 32'(rsp_valid_b), 32'd0);
        chk("b_r_rdy",  32'(cmd_ready_b), 32'd1);

        // ---------------- B: reset in the 2nd config_en cycle ----------------
        cmd_valid_b = 1'b1; cmd_write_b = 1'b1; cmd_addr_b = 32'h5; cmd_data_b = 32'h55;
        step();
        cmd_valid_b = 1'b0;
        chk("b_rw_en1", 32'(config_en_b), 32'd1);
        step();
        chk("b_rw_en2", 32'(config_en_b), 32'd1);
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        chk("b_rst_en",   32'(config_en_b),   32'd0);
        chk("b_rst_wc",   32'(write_count_b), 32'd0);
        chk("b_rst_busy", 32'(busy_b),        32'd0);
        chk("b_rst_addr", config_addr_b,      32'h0);
        chk("b_rst_rdy",  32'(cmd_ready_b),   32'd1);
        step();
        chk("b_rst_en2",  32'(config_en_b),   32'd0);
        // Next write behaves normally.
        cmd_valid_b = 1'b1; cmd_write_b = 1'b1; cmd_addr_b = 32'h6; cmd_data_b = 32'h66;
        step();
        cmd_valid_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("b_w2_en", 32'(config_en_b), 32'd1);
            step();
        end
        chk("b_w2_enof", 32'(config_en_b),   32'd0);
        chk("b_w2_wc",   32'(write_count_b), 32'd1);
        chk("b_w2_mem",  rd_b,               32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
